// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding, pe_en bit layout and info field offsets
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_CONV  = 2'd2,
    ST_COOL  = 2'd3
  } ctrl_state_t;

  // pe_en layout: [8:0] tap mask indexed 3*kr+kc, [9] array active
  localparam int PE_TAP_W   = 9;
  localparam int PE_ACT_BIT = 9;
  localparam int PE_EN_W    = 10;

  // info layout from LSB: omap_cnt, omap_icg, out channel MSB, zero pad
  localparam int INFO_OMAP_LSB = 0;

  // Counter width that never collapses to zero bits for a limit of 1
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int info_icg_lsb(input int map_w);
    return INFO_OMAP_LSB + map_w;
  endfunction

  function automatic int info_och_lsb(input int map_w, input int icg_w);
    return info_icg_lsb(map_w) + icg_w;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_gen_edge_mask.sv
// rtl/mac_array_ctrl_gen_edge_mask.sv - mac_ctrl_edge_mask: row/col position to 3x3 tap mask
module mac_ctrl_edge_mask
  import mac_ctrl_pkg::*;
#(
  parameter int FMAP_H = 56,
  parameter int FMAP_W = 56,
  parameter int ROW_W  = clog2_min1(FMAP_H),
  parameter int COL_W  = clog2_min1(FMAP_W)
) (
  input  logic [ROW_W-1:0]    i_row,
  input  logic [COL_W-1:0]    i_col,
  output logic [PE_TAP_W-1:0] o_tap_mask
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);

  logic w_top;
  logic w_bot;
  logic w_left;
  logic w_right;

  assign w_top   = (i_row == '0);
  assign w_bot   = (i_row == ROW_LAST);
  assign w_left  = (i_col == '0);
  assign w_right = (i_col == COL_LAST);

  // A tap is dropped when its kernel row or column falls outside the map
  always_comb begin
    o_tap_mask = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        o_tap_mask[3*kr+kc] = !((kr == 0 && w_top)  || (kr == 2 && w_bot) ||
                                (kc == 0 && w_left) || (kc == 2 && w_right));
      end
    end
  end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// rtl/sirv_gnrl_dfflr.sv - load-enabled flop bank with async active-low reset to zero
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] r_qout;

  // Capture dnxt only when the load enable is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qout <= '0;
    end else if (lden) begin
      r_qout <= dnxt;
    end
  end

  assign qout = r_qout;

endmodule

// File: rtl/mac_array_ctrl_gen.sv
// rtl/mac_array_ctrl_gen.sv - 3x3 MAC array sequencer; optional perf counters under MAC_ARRAY_CTRL_PERF_EN
module mac_array_ctrl_gen
  import mac_ctrl_pkg::*;
#(
  parameter int FMAP_H    = 56,
  parameter int FMAP_W    = 56,
  parameter int NOCH      = 64,
  parameter int NICG      = 2,
  parameter int SETUP_CYC = FMAP_W + 3,
  parameter int PIPE_LAT  = 6,
  parameter int ADDR_W    = 32,
  parameter int OCH_W     = clog2_min1(NOCH),
  parameter int ICG_W     = clog2_min1(NICG)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_conv_start,
  input  logic                 i_mac_array2psum_acc_rdy,
  output logic [OCH_W-1:0]     o_out_ch_cnt,
  output logic [ICG_W-1:0]     o_in_ch_cnt,
  output logic                 o_mac_array2psum_acc_vld,
  output logic [ADDR_W-1:0]    o_mac_array2psum_acc_info,
  output logic                 o_conv_done,
  output logic                 o_pipe_en,
  output logic [PE_EN_W-1:0]   o_pe_en,
  output logic [ICG_W:0]       o_weight_sel,
  output logic [ADDR_W-1:0]    o_imap_raddr,
  output logic                 o_imap_ren,
  output logic [4:0]           o_identity_sel
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]          o_perf_stall_cnt,
  output logic [31:0]          o_perf_busy_cnt
`endif
);

  localparam int MAP_PIX  = FMAP_H * FMAP_W;
  localparam int ROW_W    = clog2_min1(FMAP_H);
  localparam int COL_W    = clog2_min1(FMAP_W);
  localparam int MAP_W    = clog2_min1(MAP_PIX);
  localparam int SET_W    = clog2_min1(SETUP_CYC);
  localparam int RD_TOTAL = NOCH * NICG * MAP_PIX;
  localparam int RD_W     = $clog2(RD_TOTAL + 1);
  localparam int ICG_LSB  = info_icg_lsb(MAP_W);
  localparam int OCH_LSB  = info_och_lsb(MAP_W, ICG_W);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(MAP_PIX - 1);
  localparam logic [ICG_W-1:0] ICG_LAST = ICG_W'(NICG - 1);
  localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(NOCH - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYC - 1);
  localparam logic [RD_W-1:0]  RD_LIMIT = RD_W'(RD_TOTAL);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic [SET_W-1:0]    r_setup_cnt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ICG_W-1:0]    r_in_ch_cnt;
  logic [OCH_W-1:0]    r_out_ch_cnt;
  logic [MAP_W-1:0]    r_imap_cnt;
  logic [ICG_W-1:0]    r_rd_icg;
  logic [RD_W-1:0]     r_reads_issued;
  logic [MAP_W-1:0]    r_omap_cnt;
  logic [ICG_W-1:0]    r_omap_icg;
  logic [OCH_W-1:0]    r_omap_och;
  logic                r_conv_done;

  logic                w_start;
  logic                w_pipe_en;
  logic                w_in_conv;
  logic                w_conv_adv;
  logic                w_setup_last;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_icg_last;
  logic                w_och_last;
  logic                w_comp_last;
  logic                w_imap_ren;
  logic                w_imap_wrap;
  logic                w_vld;
  logic                w_beat;
  logic                w_omap_wrap;
  logic                w_omap_last;
  logic [PIPE_LAT-1:0] w_dly_d;
  logic [PIPE_LAT-1:0] w_dly_q;
  logic [PE_TAP_W-1:0] w_tap_mask;
  logic [ADDR_W-1:0]   w_info;
  logic [ADDR_W-1:0]   w_raddr;

  assign w_start      = (r_state == ST_IDLE) && i_conv_start;
  assign w_pipe_en    = (r_state != ST_IDLE) && i_mac_array2psum_acc_rdy;
  assign w_in_conv    = (r_state == ST_CONV);
  assign w_conv_adv   = w_pipe_en && w_in_conv;
  assign w_setup_last = (r_setup_cnt == SET_LAST);
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_icg_last   = (r_in_ch_cnt == ICG_LAST);
  assign w_och_last   = (r_out_ch_cnt == OCH_LAST);
  assign w_comp_last  = w_col_last && w_row_last && w_icg_last && w_och_last;
  assign w_imap_ren   = w_pipe_en && (r_reads_issued < RD_LIMIT);
  assign w_imap_wrap  = (r_imap_cnt == MAP_LAST);
  assign w_beat       = w_vld && i_mac_array2psum_acc_rdy;
  assign w_omap_wrap  = (r_omap_cnt == MAP_LAST);
  assign w_omap_last  = w_omap_wrap && (r_omap_icg == ICG_LAST) && (r_omap_och == OCH_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: prefetch, compute every pass back to back, drain the pipeline
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_conv_start) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_pipe_en && w_setup_last) w_state_nxt = ST_CONV;
      ST_CONV:  if (w_conv_adv && w_comp_last) w_state_nxt = ST_COOL;
      ST_COOL:  if (w_beat && w_omap_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Prefetch counter, counts stalled-free setup cycles only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_setup_cnt <= '0;
    end else if (w_start) begin
      r_setup_cnt <= '0;
    end else if (w_pipe_en && (r_state == ST_SETUP)) begin
      r_setup_cnt <= w_setup_last ? '0 : r_setup_cnt + 1'b1;
    end
  end

  // Compute position: col -> row -> input group -> output channel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_in_ch_cnt  <= '0;
      r_out_ch_cnt <= '0;
    end else if (w_start) begin
      r_col        <= '0;
      r_row        <= '0;
      r_in_ch_cnt  <= '0;
      r_out_ch_cnt <= '0;
    end else if (w_conv_adv) begin
      r_col <= w_col_last ? '0 : r_col + 1'b1;
      if (w_col_last) begin
        r_row <= w_row_last ? '0 : r_row + 1'b1;
        if (w_row_last) begin
          r_in_ch_cnt <= w_icg_last ? '0 : r_in_ch_cnt + 1'b1;
          if (w_icg_last) begin
            r_out_ch_cnt <= w_och_last ? '0 : r_out_ch_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Read side runs SETUP_CYC ahead of compute and stops after the last pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imap_cnt     <= '0;
      r_rd_icg       <= '0;
      r_reads_issued <= '0;
    end else if (w_start) begin
      r_imap_cnt     <= '0;
      r_rd_icg       <= '0;
      r_reads_issued <= '0;
    end else if (w_imap_ren) begin
      r_imap_cnt     <= w_imap_wrap ? '0 : r_imap_cnt + 1'b1;
      r_reads_issued <= r_reads_issued + 1'b1;
      if (w_imap_wrap) begin
        r_rd_icg <= (r_rd_icg == ICG_LAST) ? '0 : r_rd_icg + 1'b1;
      end
    end
  end

  // Valid follows CONV through the MAC array latency
  generate
    if (PIPE_LAT == 1) begin : g_dly_one
      assign w_dly_d = w_in_conv;
    end else begin : g_dly_shift
      assign w_dly_d = {w_dly_q[PIPE_LAT-2:0], w_in_conv};
    end
  endgenerate

  sirv_gnrl_dfflr #(
    .DW (PIPE_LAT)
  ) u_vld_dly (
    .lden  (w_pipe_en),
    .dnxt  (w_dly_d),
    .qout  (w_dly_q),
    .clk   (i_clk),
    .rst_n (i_rst_n)
  );

  assign w_vld = w_dly_q[PIPE_LAT-1];

  // Output-side position, advanced only by accepted beats
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_omap_cnt <= '0;
      r_omap_icg <= '0;
      r_omap_och <= '0;
    end else if (w_start) begin
      r_omap_cnt <= '0;
      r_omap_icg <= '0;
      r_omap_och <= '0;
    end else if (w_beat) begin
      r_omap_cnt <= w_omap_wrap ? '0 : r_omap_cnt + 1'b1;
      if (w_omap_wrap) begin
        r_omap_icg <= (r_omap_icg == ICG_LAST) ? '0 : r_omap_icg + 1'b1;
        if (r_omap_icg == ICG_LAST) begin
          r_omap_och <= (r_omap_och == OCH_LAST) ? '0 : r_omap_och + 1'b1;
        end
      end
    end
  end

  // Completion pulse on the final accepted beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conv_done <= 1'b0;
    end else begin
      r_conv_done <= (r_state == ST_COOL) && w_beat && w_omap_last;
    end
  end

  mac_ctrl_edge_mask #(
    .FMAP_H (FMAP_H),
    .FMAP_W (FMAP_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_edge_mask (
    .i_row      (r_row),
    .i_col      (r_col),
    .o_tap_mask (w_tap_mask)
  );

  // PE enables exist only while computing
  always_comb begin
    o_pe_en = '0;
    if (w_in_conv) begin
      o_pe_en[PE_ACT_BIT]    = 1'b1;
      o_pe_en[PE_TAP_W-1:0]  = w_tap_mask;
    end
  end

  // Pack psum info and imap address fields
  always_comb begin
    w_info = '0;
    w_info[INFO_OMAP_LSB +: MAP_W] = r_omap_cnt;
    w_info[ICG_LSB +: ICG_W]       = r_omap_icg;
    w_info[OCH_LSB]                = r_out_ch_cnt[OCH_W-1];
    w_raddr = '0;
    w_raddr[MAP_W-1:0]             = r_imap_cnt;
    w_raddr[MAP_W +: ICG_W]        = r_rd_icg;
  end

  assign o_out_ch_cnt              = r_out_ch_cnt;
  assign o_in_ch_cnt               = r_in_ch_cnt;
  assign o_mac_array2psum_acc_vld  = w_vld;
  assign o_mac_array2psum_acc_info = w_info;
  assign o_conv_done               = r_conv_done;
  assign o_pipe_en                 = w_pipe_en;
  assign o_weight_sel              = {r_out_ch_cnt[0], r_in_ch_cnt};
  assign o_imap_raddr              = w_raddr;
  assign o_imap_ren                = w_imap_ren;
  assign o_identity_sel            = 5'(r_out_ch_cnt);

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_busy_cnt;

  // Saturating busy/stall counters, cleared by a new run and frozen when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_busy_cnt  <= '0;
    end else if (w_start) begin
      r_perf_stall_cnt <= '0;
      r_perf_busy_cnt  <= '0;
    end else if (r_state != ST_IDLE) begin
      if (r_perf_busy_cnt != '1) begin
        r_perf_busy_cnt <= r_perf_busy_cnt + 1'b1;
      end
      if (!i_mac_array2psum_acc_rdy && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_busy_cnt  = r_perf_busy_cnt;
`else
  // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_mac_array_ctrl_gen.sv
// tb/tb_mac_array_ctrl_gen.sv - directed bench for mac_array_ctrl_gen, 4x4 map, 2 out ch, 2 in groups
module tb_mac_array_ctrl_gen;

  localparam int H     = 4;
  localparam int W     = 4;
  localparam int NOCH  = 2;
  localparam int NICG  = 2;
  localparam int SETUP = 7;
  localparam int LAT   = 6;
  localparam int TOTAL = H * W * NOCH * NICG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv_start = 1'b0;
  logic        rdy = 1'b1;
  logic [0:0]  out_ch_cnt;
  logic [0:0]  in_ch_cnt;
  logic        vld;
  logic [31:0] info;
  logic        done;
  logic        pipe_en;
  logic [9:0]  pe_en;
  logic [1:0]  weight_sel;
  logic [31:0] raddr;
  logic        ren;
  logic [4:0]  ident;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_busy;
`endif

  mac_array_ctrl_gen #(
    .FMAP_H(H), .FMAP_W(W), .NOCH(NOCH), .NICG(NICG),
    .SETUP_CYC(SETUP), .PIPE_LAT(LAT), .ADDR_W(32)
  ) dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_conv_start              (conv_start),
    .i_mac_array2psum_acc_rdy  (rdy),
    .o_out_ch_cnt              (out_ch_cnt),
    .o_in_ch_cnt               (in_ch_cnt),
    .o_mac_array2psum_acc_vld  (vld),
    .o_mac_array2psum_acc_info (info),
    .o_conv_done               (done),
    .o_pipe_en                 (pipe_en),
    .o_pe_en                   (pe_en),
    .o_weight_sel              (weight_sel),
    .o_imap_raddr              (raddr),
    .o_imap_ren                (ren),
    .o_identity_sel            (ident)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    ,
    .o_perf_stall_cnt          (perf_stall),
    .o_perf_busy_cnt           (perf_busy)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int res_setup, res_conv, res_beats, res_ren, res_done, res_vld_lat, res_done_lat;
  int res_pe_err, res_info_err, res_raddr_err, res_hold_err, res_busy;
  int res_timeout, res_aborted;
  logic [9:0] res_pe00, res_pe11, res_pe33;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected pe_en at compute index c: active bit plus taps that stay inside the map
  function automatic logic [9:0] exp_pe(input int c);
    int pix = c % (H * W);
    int row = pix / W;
    int col = pix % W;
    logic [9:0] m = 10'h200;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        if (!((row == 0 && kr == 0) || (row == H-1 && kr == 2) ||
              (col == 0 && kc == 0) || (col == W-1 && kc == 2)))
          m[3*kr+kc] = 1'b1;
    return m;
  endfunction

  // Beat k: omap_cnt in [3:0], group in [4], compute out channel MSB in [5]
  function automatic logic [31:0] exp_info(input int k);
    int j   = k + LAT;
    int och = (j < TOTAL) ? j / (H * W * NICG) : 0;
    return 32'(och * 32 + ((k / (H * W)) % NICG) * 16 + k % (H * W));
  endfunction

  task automatic run(input int rdy_mode, input bit spam, input int abort_at);
    int conv_idx = 0, beat_k = 0, rd_k = 0, stall_left = 0;
    int conv_first = -1, vld_first = -1, last_beat = -1, done_cyc = -1;
    bit held = 0, stall_done = 0;
    logic [31:0] held_info = '0;
    res_setup = 0; res_ren = 0; res_done = 0; res_pe_err = 0; res_info_err = 0;
    res_raddr_err = 0; res_hold_err = 0; res_busy = 0; res_timeout = 0; res_aborted = 0;
    res_pe00 = '0; res_pe11 = '0; res_pe33 = '0;
    @(posedge clk); #1;
    conv_start = 1'b1;
    rdy = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      conv_start = 1'b0;
      if (rdy_mode == 2 && conv_idx == 20 && !stall_done) begin
        stall_left = 10;
        stall_done = 1;
      end
      if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else rdy = 1'b1;
      #1;
      if (done) begin res_done++; done_cyc = cyc; break; end
      res_busy++;
      if (held && (!vld || info !== held_info)) res_hold_err++;
      held = vld && !rdy;
      held_info = info;
      if (pe_en[9]) begin
        if (conv_first < 0) conv_first = cyc;
        if (pe_en !== exp_pe(conv_idx) ||
            out_ch_cnt !== 1'(conv_idx / (H*W*NICG)) ||
            in_ch_cnt !== 1'((conv_idx / (H*W)) % NICG) ||
            weight_sel !== {1'(conv_idx / (H*W*NICG)), 1'((conv_idx / (H*W)) % NICG)} ||
            ident !== 5'(conv_idx / (H*W*NICG)))
          res_pe_err++;
        if (conv_idx == 0)  res_pe00 = pe_en;
        if (conv_idx == 5)  res_pe11 = pe_en;
        if (conv_idx == 15) res_pe33 = pe_en;
        if (pipe_en) conv_idx++;
      end else if (conv_first < 0 && pipe_en) begin
        res_setup++;
      end
      if (vld && vld_first < 0) vld_first = cyc;
      if (ren) begin
        if (raddr !== 32'(((rd_k / (H*W)) % NICG) * 16 + rd_k % (H*W))) res_raddr_err++;
        rd_k++;
      end
      if (vld && rdy) begin
        if (info !== exp_info(beat_k)) res_info_err++;
        beat_k++;
        last_beat = cyc;
      end
      if (abort_at >= 0 && conv_idx == abort_at) begin res_aborted = 1; break; end
      conv_start = spam && conv_first >= 0;
    end
    conv_start = 1'b0;
    if (res_done == 0 && res_aborted == 0) res_timeout = 1;
    res_conv     = conv_idx;
    res_beats    = beat_k;
    res_ren      = rd_k;
    res_vld_lat  = (conv_first >= 0 && vld_first >= 0) ? vld_first - conv_first : -1;
    res_done_lat = (done_cyc >= 0 && last_beat >= 0) ? done_cyc - last_beat : -1;
  endtask

  task automatic idle_chk(input string tag);
    int bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      rdy = 1'b1;
      #1;
      if (pipe_en || vld || done || ren || pe_en != 10'd0) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_info_raddr", {info, raddr}, 64'd0);
    chk("reset_ctrl", 64'({out_ch_cnt, in_ch_cnt, vld, done, pipe_en, pe_en, weight_sel, ren, ident}), 64'd0);
    rst_n = 1'b1;

    run(0, 0, -1);
    chk("a_timeout", 64'(res_timeout), 64'd0);
    chk("a_setup_cycles", 64'(res_setup), 64'(SETUP));
    chk("a_conv_cycles", 64'(res_conv), 64'(TOTAL));
    chk("a_beats", 64'(res_beats), 64'(TOTAL));
    chk("a_imap_ren", 64'(res_ren), 64'(TOTAL));
    chk("a_done_count", 64'(res_done), 64'd1);
    chk("a_vld_latency", 64'(res_vld_lat), 64'(LAT));
    chk("a_done_latency", 64'(res_done_lat), 64'd1);
    chk("a_pe_r0c0", 64'(res_pe00), 64'(10'b1110110000));
    chk("a_pe_r1c1", 64'(res_pe11), 64'(10'b1111111111));
    chk("a_pe_r3c3", 64'(res_pe33), 64'(10'b1000011011));
    chk("a_pe_counters", 64'(res_pe_err), 64'd0);
    chk("a_info", 64'(res_info_err), 64'd0);
    chk("a_raddr", 64'(res_raddr_err), 64'd0);
    idle_chk("a_idle_after");

    run(1, 0, -1);
    chk("b_timeout", 64'(res_timeout), 64'd0);
    chk("b_setup_cycles", 64'(res_setup), 64'(SETUP));
    chk("b_conv_cycles", 64'(res_conv), 64'(TOTAL));
    chk("b_beats", 64'(res_beats), 64'(TOTAL));
    chk("b_imap_ren", 64'(res_ren), 64'(TOTAL));
    chk("b_info", 64'(res_info_err), 64'd0);
    chk("b_info_hold", 64'(res_hold_err), 64'd0);
    chk("b_pe_counters", 64'(res_pe_err), 64'd0);
    chk("b_done_latency", 64'(res_done_lat), 64'd1);

    run(0, 1, -1);
    chk("c_timeout", 64'(res_timeout), 64'd0);
    chk("c_conv_cycles", 64'(res_conv), 64'(TOTAL));
    chk("c_beats", 64'(res_beats), 64'(TOTAL));
    chk("c_done_count", 64'(res_done), 64'd1);
    idle_chk("c_no_restart");

    run(0, 0, 30);
    chk("d_aborted", 64'(res_aborted), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("d_abort_info_raddr", {info, raddr}, 64'd0);
    chk("d_abort_ctrl", 64'({out_ch_cnt, in_ch_cnt, vld, done, pipe_en, pe_en, weight_sel, ren, ident}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("d_no_done_in_reset", 64'(done), 64'd0);
    rst_n = 1'b1;

    run(0, 0, -1);
    chk("e_timeout", 64'(res_timeout), 64'd0);
    chk("e_conv_cycles", 64'(res_conv), 64'(TOTAL));
    chk("e_beats", 64'(res_beats), 64'(TOTAL));
    chk("e_imap_ren", 64'(res_ren), 64'(TOTAL));
    chk("e_info", 64'(res_info_err), 64'd0);
    chk("e_raddr", 64'(res_raddr_err), 64'd0);
    chk("e_done_count", 64'(res_done), 64'd1);

`ifdef MAC_ARRAY_CTRL_PERF_EN
    run(2, 0, -1);
    chk("f_timeout", 64'(res_timeout), 64'd0);
    chk("f_info", 64'(res_info_err), 64'd0);
    chk("f_perf_stall", 64'(perf_stall), 64'd10);
    chk("f_perf_busy", 64'(perf_busy), 64'(res_busy));
    chk("f_perf_busy_total", 64'(res_busy), 64'(SETUP + TOTAL + LAT + 10));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
